ecap5_dwbarb: RTL and testbench

Two-master to one-slave Wishbone B4 pipelined arbiter. It sits directly upstream of the data BRAM slave, `ecap5_dwbmem_bram`. It lets two bus masters share the memory port, typically a load/store unit and a debug/boot loader. Bus ownership is granted per Wishbone cycle (`cyc` span), with round-robin or fixed priority on ties. The granted master's signals are routed combinationally to the slave.

---
 rtl/ecap5_dwbarb.sv | 121 ++++++++++++
 tb/tb_ecap5_dwbarb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecap5_dwbarb.sv
// Two-master to one-slave Wishbone B4 pipelined arbiter.
// Ownership is held for a whole cyc span; routing is purely combinational.
module ecap5_dwbarb #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,

  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,

  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
  } wb_req_t;

  state_t  state_q, state_d;
  logic    last_q, last_d;   // 0: m0 granted last, 1: m1 granted last
  wb_req_t req0, req1, sreq;
  logic    gnt0, gnt1;

  assign req0 = {m0_wb_adr_i, m0_wb_dat_i, m0_wb_we_i, m0_wb_sel_i, m0_wb_stb_i, m0_wb_cyc_i};
  assign req1 = {m1_wb_adr_i, m1_wb_dat_i, m1_wb_we_i, m1_wb_sel_i, m1_wb_stb_i, m1_wb_cyc_i};

  // last_q resets to m1 so the first round-robin tie goes to m0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && (!m1_wb_cyc_i || FIXED_PRIORITY != 0 || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_wb_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0:    if (!m0_wb_cyc_i) state_d = IDLE;
      GNT1:    if (!m1_wb_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sreq = '0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      GNT0: begin
        sreq = req0;
        gnt0 = 1'b1;
      end
      GNT1: begin
        sreq = req1;
        gnt1 = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_wb_adr_o = sreq.adr;
  assign s_wb_dat_o = sreq.dat;
  assign s_wb_we_o  = sreq.we;
  assign s_wb_sel_o = sreq.sel;
  assign s_wb_stb_o = sreq.stb;
  assign s_wb_cyc_o = sreq.cyc;

  // Responses in IDLE (including late acks) reach nobody
  assign m0_wb_dat_o   = gnt0 ? s_wb_dat_i : '0;
  assign m0_wb_ack_o   = gnt0 & s_wb_ack_i;
  assign m0_wb_stall_o = ~gnt0 | s_wb_stall_i;
  assign m1_wb_dat_o   = gnt1 ? s_wb_dat_i : '0;
  assign m1_wb_ack_o   = gnt1 & s_wb_ack_i;
  assign m1_wb_stall_o = ~gnt1 | s_wb_stall_i;

endmodule

// File: tb/tb_ecap5_dwbarb.sv
// Bench for ecap5_dwbarb: round-robin (a) and fixed-priority (b) instances share stimulus;
// an owner-level model predicts every routed output, a bench slave answers dut a.
module tb_ecap5_dwbarb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack_i, s_stall_i;
  logic [3:0]  m0_sel, m1_sel;

  logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat, b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
  logic        a_m0_ack, a_m0_stall, a_m1_ack, a_m1_stall, a_s_we, a_s_stb, a_s_cyc;
  logic        b_m0_ack, b_m0_stall, b_m1_ack, b_m1_stall, b_s_we, b_s_stb, b_s_cyc;
  logic [3:0]  a_s_sel, b_s_sel;

  ecap5_dwbarb #(.FIXED_PRIORITY(0)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_dat_o(a_m0_dat), .m0_wb_we_i(m0_we),
    .m0_wb_sel_i(m0_sel), .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc), .m0_wb_ack_o(a_m0_ack),
    .m0_wb_stall_o(a_m0_stall),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_dat_o(a_m1_dat), .m1_wb_we_i(m1_we),
    .m1_wb_sel_i(m1_sel), .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc), .m1_wb_ack_o(a_m1_ack),
    .m1_wb_stall_o(a_m1_stall),
    .s_wb_adr_o(a_s_adr), .s_wb_dat_o(a_s_dat), .s_wb_we_o(a_s_we), .s_wb_sel_o(a_s_sel),
    .s_wb_stb_o(a_s_stb), .s_wb_cyc_o(a_s_cyc), .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack_i),
    .s_wb_stall_i(s_stall_i));

  ecap5_dwbarb #(.FIXED_PRIORITY(1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_dat_o(b_m0_dat), .m0_wb_we_i(m0_we),
    .m0_wb_sel_i(m0_sel), .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc), .m0_wb_ack_o(b_m0_ack),
    .m0_wb_stall_o(b_m0_stall),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_dat_o(b_m1_dat), .m1_wb_we_i(m1_we),
    .m1_wb_sel_i(m1_sel), .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc), .m1_wb_ack_o(b_m1_ack),
    .m1_wb_stall_o(b_m1_stall),
    .s_wb_adr_o(b_s_adr), .s_wb_dat_o(b_s_dat), .s_wb_we_o(b_s_we), .s_wb_sel_o(b_s_sel),
    .s_wb_stb_o(b_s_stb), .s_wb_cyc_o(b_s_cyc), .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack_i),
    .s_wb_stall_i(s_stall_i));

  logic [138:0] a_vec, b_vec;
  assign a_vec = {a_s_adr, a_s_dat, a_s_we, a_s_sel, a_s_stb, a_s_cyc,
                  a_m0_dat, a_m0_ack, a_m0_stall, a_m1_dat, a_m1_ack, a_m1_stall};
  assign b_vec = {b_s_adr, b_s_dat, b_s_we, b_s_sel, b_s_stb, b_s_cyc,
                  b_m0_dat, b_m0_ack, b_m0_stall, b_m1_dat, b_m1_ack, b_m1_stall};

  int n_chk = 0;
  int n_fail = 0;

  // Model: owner of the bus (-1 none) and most recent grantee, per instance
  int own [2];
  int last[2];

  logic [31:0] mem [logic [31:0]];
  logic        acc, acc_we;
  logic [31:0] acc_adr, acc_dat;
  logic [3:0]  acc_sel;
  int          acc_cnt;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [138:0] expv(input int o);
    logic [31:0] sa, sd, d0, d1;
    logic        swe, sstb, scyc, k0, k1, st0, st1;
    logic [3:0]  ssel;
    {sa, sd, swe, ssel, sstb, scyc} = '0;
    {d0, d1, k0, k1} = '0;
    st0 = 1'b1;
    st1 = 1'b1;
    if (o == 0) begin
      {sa, sd, swe, ssel, sstb, scyc} = {m0_adr, m0_dat, m0_we, m0_sel, m0_stb, m0_cyc};
      {d0, k0, st0} = {s_dat_i, s_ack_i, s_stall_i};
    end else if (o == 1) begin
      {sa, sd, swe, ssel, sstb, scyc} = {m1_adr, m1_dat, m1_we, m1_sel, m1_stb, m1_cyc};
      {d1, k1, st1} = {s_dat_i, s_ack_i, s_stall_i};
    end
    return {sa, sd, swe, ssel, sstb, scyc, d0, k0, st0, d1, k1, st1};
  endfunction

  // Sample the current cycle: compare both instances, note slave acceptance
  task automatic smp();
    logic [138:0] e;
    @(negedge clk);
    e = expv(own[0]);
    n_chk++;
    if (a_vec !== e) begin
      n_fail++;
      $display("FAIL route_rr: got %h expected %h (t=%0t)", a_vec, e, $time);
    end
    e = expv(own[1]);
    n_chk++;
    if (b_vec !== e) begin
      n_fail++;
      $display("FAIL route_fp: got %h expected %h (t=%0t)", b_vec, e, $time);
    end
    acc = a_s_cyc & a_s_stb & ~s_stall_i;
    {acc_adr, acc_dat, acc_we, acc_sel} = {a_s_adr, a_s_dat, a_s_we, a_s_sel};
    if (acc) acc_cnt++;
  endtask

  // Advance one edge: model update, then the slave answers one cycle after acceptance
  task automatic adv();
    int nown[2];
    int nlast[2];
    logic [31:0] old;
    for (int k = 0; k < 2; k++) begin
      nown[k] = own[k];
      nlast[k] = last[k];
      if (rst) begin
        nown[k] = -1;
        nlast[k] = 1;
      end else if (own[k] == -1) begin
        if (m0_cyc && m1_cyc) nown[k] = (k == 1) ? 0 : 1 - last[k];
        else if (m0_cyc)      nown[k] = 0;
        else if (m1_cyc)      nown[k] = 1;
        if (nown[k] != -1) nlast[k] = nown[k];
      end else if (!((own[k] == 0) ? m0_cyc : m1_cyc)) begin
        nown[k] = -1;
      end
    end
    @(posedge clk);
    #1;
    own = nown;
    last = nlast;
    old = mem.exists(acc_adr) ? mem[acc_adr] : 32'h0;
    s_ack_i = acc;
    s_dat_i = (acc && !acc_we) ? old : 32'h0;
    if (acc && acc_we)
      for (int i = 0; i < 4; i++)
        if (acc_sel[i]) old[i*8 +: 8] = acc_dat[i*8 +: 8];
    if (acc && acc_we) mem[acc_adr] = old;
    acc = 1'b0;
  endtask

  task automatic cyc1();
    smp();
    adv();
  endtask

  initial begin
    rst = 1'b1;
    {m0_adr, m0_dat, m0_we, m0_sel, m0_stb, m0_cyc} = '0;
    {m1_adr, m1_dat, m1_we, m1_sel, m1_stb, m1_cyc} = '0;
    {s_dat_i, s_ack_i, s_stall_i} = '0;
    acc = 1'b0;
    acc_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    own = '{-1, -1};
    last = '{1, 1};

    // reset values
    smp();
    chk("rst_stall", {a_m0_stall, a_m1_stall, b_m0_stall, b_m1_stall}, 64'hF);
    chk("rst_s_cyc_stb", {a_s_cyc, a_s_stb, a_m0_ack, a_m1_ack}, 64'h0);
    adv();
    rst = 1'b0;

    // m0 alone: write then read 0x10
    {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat, m0_sel} = {1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF};
    smp();
    chk("grant_latency_idle", a_s_cyc, 64'h0);
    adv();
    smp();
    chk("m0_first_req", {a_s_cyc, a_s_stb, a_s_adr}, {62'h0, 1'b1, 1'b1} << 32 | 64'h10);
    adv();
    {m0_stb, m0_we} = 2'b00;
    smp();
    chk("m0_write_ack", a_m0_ack, 64'h1);
    adv();
    {m0_stb, m0_we} = 2'b10;
    cyc1();
    m0_stb = 1'b0;
    smp();
    chk("m0_read_data", {a_m0_ack, a_m0_dat}, 64'h1_DEADBEEF);
    chk("m0_alone_m1_stall", a_m1_stall, 64'h1);
    adv();
    m0_cyc = 1'b0;
    cyc1();
    cyc1();

    // tie after reset: m0, one dead cycle, m1, then m0 again
    rst = 1'b1;
    cyc1();
    rst = 1'b0;
    {m0_cyc, m1_cyc} = 2'b11;
    cyc1();
    smp();
    chk("tie1_m0", {a_m0_stall, a_m1_stall, a_s_cyc}, 64'b011);
    adv();
    m0_cyc = 1'b0;
    cyc1();
    smp();
    chk("handover_dead", {a_m1_stall, a_s_cyc}, 64'b10);
    adv();
    smp();
    chk("tie1_m1_next", {a_m1_stall, a_s_cyc}, 64'b01);
    adv();
    m1_cyc = 1'b0;
    cyc1();
    cyc1();
    {m0_cyc, m1_cyc} = 2'b11;
    cyc1();
    smp();
    chk("tie2_m0", {a_m0_stall, a_m1_stall}, 64'b01);
    adv();
    {m0_cyc, m1_cyc} = 2'b00;
    cyc1();
    cyc1();

    // fixed priority: three back-to-back ties all to m0
    for (int i = 0; i < 3; i++) begin
      {m0_cyc, m1_cyc} = 2'b11;
      cyc1();
      smp();
      chk("fp_tie_m0", {b_m0_stall, b_m1_stall}, 64'b01);
      adv();
      {m0_cyc, m1_cyc} = 2'b00;
      cyc1();
    end
    cyc1();

    // no preemption: m0 bursts for 20 cycles while m1 waits with stb up
    m0_cyc = 1'b1;
    cyc1();
    {m1_cyc, m1_stb, m1_we, m1_adr, m1_sel} = {1'b1, 1'b1, 1'b0, 32'h8000_0000, 4'hF};
    for (int i = 0; i < 20; i++) begin
      {m0_stb, m0_we, m0_adr} = {1'b1, 1'b0, 32'h100 + 32'(i) * 4};
      smp();
      chk("nopre_m1_blocked", {a_m1_stall, a_m1_ack}, 64'b10);
      chk("nopre_no_m1_adr", a_s_adr == 32'h8000_0000, 64'h0);
      adv();
    end
    {m0_cyc, m0_stb} = 2'b00;
    cyc1();
    cyc1();
    smp();
    chk("m1_after_burst", {a_s_stb, a_s_adr}, 64'h1_8000_0000);
    adv();
    m1_stb = 1'b0;
    cyc1();
    m1_cyc = 1'b0;
    cyc1();
    cyc1();

    // stall pass-through: accepted exactly once on the first unstalled cycle
    m0_cyc = 1'b1;
    cyc1();
    {m0_stb, m0_we, m0_adr} = {1'b1, 1'b0, 32'h10};
    s_stall_i = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("stall_mirror_hi", a_m0_stall, 64'h1);
      adv();
    end
    s_stall_i = 1'b0;
    smp();
    chk("stall_mirror_lo", a_m0_stall, 64'h0);
    adv();
    m0_stb = 1'b0;
    smp();
    chk("stall_read_data", {a_m0_ack, a_m0_dat}, 64'h1_DEADBEEF);
    adv();
    chk("stall_accept_once", acc_cnt, 64'h1);
    m0_cyc = 1'b0;
    cyc1();
    cyc1();

    // reset mid-grant with an ack pending
    {m1_cyc, m1_stb, m1_adr} = {1'b1, 1'b0, 32'h10};
    cyc1();
    {m1_stb, rst} = 2'b11;
    smp();
    chk("rst_grant_active", {a_s_cyc, a_s_stb, a_m1_stall}, 64'b110);
    adv();
    {m1_stb, rst} = 2'b00;
    smp();
    chk("rst_late_ack_dropped", {s_ack_i, a_m1_ack, a_m1_stall, a_s_cyc}, 64'b1010);
    adv();
    smp();
    chk("rst_regrant_m1", {a_m1_stall, a_s_cyc}, 64'b01);
    adv();
    m1_stb = 1'b1;
    cyc1();
    m1_stb = 1'b0;
    smp();
    chk("rst_m1_read", {a_m1_ack, a_m1_dat}, 64'h1_DEADBEEF);
    adv();
    m1_cyc = 1'b0;
    cyc1();
    cyc1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
